mem_responder: RTL and testbench

- Memory-side responder for the multicycle CPU's data/instruction bus. It answers the CPU's address/write/data requests through a valid/ready handshake with a configurable number of wait states.
- Holds word storage and returns read data with an acknowledge. Flags misaligned or out-of-range accesses instead of silently wrapping.
- Sits between the CPU's address mux output and the storage. It replaces the fixed-latency memory so the control FSM can be exercised against variable latency.

---
 rtl/mem_resp_pkg.sv | 26 ++
 rtl/mem_array_sp.sv | 29 ++
 rtl/mem_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder slice.
//   state_t    : responder FSM states (CLEAR walks the storage after reset)
//   WORD_BYTES : bytes per storage word
//   ERR_W      : width of the response error code
//   addr_err() : misalignment / out-of-range check for a byte address
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int ERR_W      = 1;

    // A byte address is bad when it is not word aligned or its word index is
    // past the end of storage. Upper address bits are never discarded.
    function automatic logic addr_err(input logic [31:0] addr, input int depth_words);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= 32'(depth_words));
    endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port synchronous word RAM, read-before-write, registered read data.
// No reset: contents are owned and initialised by the controlling FSM.
//   clock : rising-edge clock
//   we    : write enable for addr
//   addr  : word index
//   wdata : write data
//   rdata : word at addr as it was before this edge's write
module mem_array_sp #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Storage write and registered read of the addressed word.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU data/instruction bus. Accepts one word
// request at a time through valid/ready, waits WAIT_CYCLES, then returns a
// one-cycle acknowledge with read data and an error flag.
//   clock      : rising-edge clock
//   reset      : synchronous, active-low
//   req_valid  : request present           req_ready : accepting (IDLE only)
//   req_wr     : 1 = write                 req_addr  : byte address
//   req_wdata  : write data
//   rsp_ack    : one-cycle completion pulse
//   rsp_rdata  : read data, held until the next acknowledge
//   rsp_err    : misaligned or out-of-range access
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int INIT_ZERO   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    state_t        state_r;
    logic [3:0]    wait_cnt_r;
    logic [AW-1:0] clr_cnt_r;
    logic          wr_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic          err_pend_r;
    logic          ack_r;
    logic          err_r;
    logic [31:0]   rdata_r;

    logic          accept_s;
    logic          enter_resp_s;
    logic          acc_wr_s;
    logic [31:0]   acc_addr_s;
    logic [31:0]   acc_wdata_s;
    logic          acc_err_s;
    logic          ram_we_s;
    logic [AW-1:0] ram_addr_s;
    logic [31:0]   ram_wdata_s;
    logic [31:0]   ram_rdata_s;

    assign accept_s = reset && req_valid && (state_r == IDLE);

    // The storage access happens on the edge that enters RESP. With no wait
    // states that edge is the accept edge itself, so the live request is used.
    assign enter_resp_s = reset && ((NO_WAIT && accept_s) ||
                                    ((state_r == WAIT) && (wait_cnt_r == 4'd0)));

    // Select the transaction fields feeding the storage access.
    always_comb begin
        acc_wr_s    = wr_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        if (state_r == IDLE) begin
            acc_wr_s    = req_wr;
            acc_addr_s  = req_addr;
            acc_wdata_s = req_wdata;
        end else begin
            acc_wr_s    = wr_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
    end

    assign acc_err_s = addr_err(acc_addr_s, DEPTH_WORDS);

    // Storage port control: the clear walk, or the transaction access.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = acc_addr_s[AW+1:2];
        ram_wdata_s = acc_wdata_s;
        if (state_r == CLEAR) begin
            ram_we_s    = 1'b1;
            ram_addr_s  = clr_cnt_r;
            ram_wdata_s = 32'h0000_0000;
        end else begin
            ram_we_s    = enter_resp_s && acc_wr_s && !acc_err_s;
            ram_addr_s  = acc_addr_s[AW+1:2];
            ram_wdata_s = acc_wdata_s;
        end
    end

    mem_array_sp #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_mem (
        .clock(clock),
        .we   (ram_we_s),
        .addr (ram_addr_s),
        .wdata(ram_wdata_s),
        .rdata(ram_rdata_s)
    );

    // Responder FSM with request latches and registered response outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r    <= (INIT_ZERO != 0) ? CLEAR : IDLE;
            wait_cnt_r <= 4'd0;
            clr_cnt_r  <= '0;
            wr_r       <= 1'b0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            err_pend_r <= 1'b0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            rdata_r    <= 32'h0000_0000;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        wr_r    <= req_wr;
                        addr_r  <= req_addr;
                        wdata_r <= req_wdata;
                        if (NO_WAIT) begin
                            state_r <= RESP;
                        end else begin
                            state_r    <= WAIT;
                            wait_cnt_r <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == 4'd0) begin
                        state_r <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    ack_r   <= 1'b1;
                    err_r   <= err_pend_r;
                    // Writes leave the previous read data in place.
                    if (err_pend_r) begin
                        rdata_r <= 32'h0000_0000;
                    end else if (!wr_r) begin
                        rdata_r <= ram_rdata_s;
                    end
                end
                CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + 1'b1;
                    if (clr_cnt_r == AW'(DEPTH_WORDS - 1)) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            if (enter_resp_s) begin
                err_pend_r <= acc_err_s;
            end
        end
    end

    assign req_ready = (state_r == IDLE);
    assign rsp_ack   = ack_r;
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (W=1/clear, W=0/clear,
// W=3/no clear), a vector table, and sequences for streaming and reset abort.
module tb_mem_responder;

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        int          ack_cyc;
    } exp_t;

    typedef struct {
        int          dut;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clock = 1'b0;
    logic        rst_n     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_wr    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_ack   [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    exp_t        exp_q[$];
    vec_t        vecs[$];
    exp_t        mon_e;
    logic [31:0] model_a [256];
    logic [31:0] slist [12];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          ack_count = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1), .INIT_ZERO(1)) dut_a (
        .clock(clock), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_wr(req_wr[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_ack(rsp_ack[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .INIT_ZERO(1)) dut_b (
        .clock(clock), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_wr(req_wr[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_ack(rsp_ack[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3), .INIT_ZERO(0)) dut_c (
        .clock(clock), .reset(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_wr(req_wr[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_ack(rsp_ack[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    function automatic int wait_of(input int d);
        if (d == 0) return 1;
        if (d == 1) return 0;
        return 3;
    endfunction

    function automatic logic bad_addr(input logic [31:0] a);
        logic [31:0] w;
        w = {2'b00, a[31:2]};
        return (a[1:0] != 2'b00) || (w >= 32'd256);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every acknowledge must match the oldest pending expectation.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (rsp_ack[i] === 1'b1) begin
                ack_count++;
                if (exp_q.size() == 0 || exp_q[0].dut != i) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_ack: dut %0d acked at cycle %0d with nothing pending", i, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("rdata_dut%0d", i), rsp_rdata[i], mon_e.rdata);
                    check($sformatf("err_dut%0d", i), {31'd0, rsp_err[i]}, {31'd0, mon_e.err});
                    check($sformatf("ack_cycle_dut%0d", i), cyc, mon_e.ack_cyc);
                    check($sformatf("ready_at_ack_dut%0d", i), {31'd0, req_ready[i]}, 32'd1);
                end
            end
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge clock);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL ack_timeout: %0d responses still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic issue(input int d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_er);
        int t;
        @(negedge clock);
        req_valid[d] = 1'b1;
        req_wr[d]    = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        t = 0;
        while (req_ready[d] !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: dut %0d ready low, expected high", d);
            req_valid[d] = 1'b0;
            return;
        end
        exp_q.push_back('{dut: d, rdata: exp_rd, err: exp_er, ack_cyc: cyc + 2 + wait_of(d)});
        if (d == 0 && wr && !bad_addr(addr)) model_a[addr[9:2]] = wdata;
        @(negedge clock);
        // Scramble the request after accept; the latched copy must be used.
        req_valid[d] = 1'b0;
        req_wr[d]    = ~wr;
        req_addr[d]  = addr ^ 32'h0000_0044;
        req_wdata[d] = 32'hFFFF_FFFF;
        drain();
    endtask

    task automatic add_vec(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] er, input logic ee);
        vecs.push_back('{dut: d, wr: wr, addr: a, wdata: wd, exp_rdata: er, exp_err: ee});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n_acc;
        int acks0;

        for (int i = 0; i < 256; i++) model_a[i] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_wr[i] = 1'b0;
            req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
        end

        // Vector table: per-DUT transactions with expected response.
        add_vec(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        add_vec(0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
        add_vec(0, 1'b1, 32'h0000_0013, 32'h1234_5678, 32'h0000_0000, 1'b1);
        add_vec(0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
        add_vec(0, 1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 1'b1);
        add_vec(0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0);
        add_vec(0, 1'b0, 32'h0000_03FC, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0);
        add_vec(0, 1'b1, 32'h0000_0014, 32'h0000_0009, 32'hA5A5_A5A5, 1'b0);
        add_vec(0, 1'b1, 32'h0000_0400, 32'h7777_7777, 32'h0000_0000, 1'b1);
        add_vec(0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1);
        add_vec(0, 1'b0, 32'h0000_0014, 32'h0000_0000, 32'h0000_0009, 1'b0);
        add_vec(1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1'b0);
        add_vec(1, 1'b1, 32'h0000_0004, 32'h55AA_55AA, 32'h0000_0000, 1'b0);
        add_vec(1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h55AA_55AA, 1'b0);
        add_vec(1, 1'b0, 32'h0000_0006, 32'h0000_0000, 32'h0000_0000, 1'b1);
        add_vec(1, 1'b1, 32'h0000_0008, 32'h0102_0304, 32'h0000_0000, 1'b0);
        add_vec(2, 1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0000_0000, 1'b0);

        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(negedge clock);

        // Reset state: clearing instances hold ready low; outputs cleared.
        check("reset_ready_a", {31'd0, req_ready[0]}, 32'd0);
        check("reset_ready_b", {31'd0, req_ready[1]}, 32'd0);
        check("reset_ready_c", {31'd0, req_ready[2]}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_ack_%0d", i), {31'd0, rsp_ack[i]}, 32'd0);
            check($sformatf("reset_err_%0d", i), {31'd0, rsp_err[i]}, 32'd0);
            check($sformatf("reset_rdata_%0d", i), rsp_rdata[i], 32'h0);
        end
        t = 0;
        while (req_ready[0] !== 1'b1 && t < 400) begin
            @(negedge clock);
            t++;
        end
        check("clear_done_a", {31'd0, req_ready[0]}, 32'd1);
        check("clear_done_b", {31'd0, req_ready[1]}, 32'd1);

        for (int k = 0; k < vecs.size(); k++) begin
            issue(vecs[k].dut, vecs[k].wr, vecs[k].addr, vecs[k].wdata,
                  vecs[k].exp_rdata, vecs[k].exp_err);
        end

        // Reset abort on dut C while its write waits.
        @(negedge clock);
        req_valid[2] = 1'b1; req_wr[2] = 1'b1;
        req_addr[2] = 32'h0000_0020; req_wdata[2] = 32'hCAFE_BABE;
        check("abort_ready_before", {31'd0, req_ready[2]}, 32'd1);
        @(negedge clock);
        rst_n[2] = 1'b0;
        req_wdata[2] = 32'hBAD0_BAD0;
        @(negedge clock);
        check("abort_ready_in_reset", {31'd0, req_ready[2]}, 32'd1);
        check("abort_ack_in_reset", {31'd0, rsp_ack[2]}, 32'd0);
        @(negedge clock);
        req_valid[2] = 1'b0;
        rst_n[2] = 1'b1;
        repeat (8) @(negedge clock);
        check("abort_ready_after", {31'd0, req_ready[2]}, 32'd1);
        issue(2, 1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111, 1'b0);

        // Streaming on dut A: valid held high, address changes every cycle.
        slist[0] = 32'h0000_0010; slist[1]  = 32'h0000_0014; slist[2]  = 32'h0000_0018;
        slist[3] = 32'h0000_03FC; slist[4]  = 32'h0000_0400; slist[5]  = 32'h0000_0013;
        slist[6] = 32'h0000_0000; slist[7]  = 32'h0000_0010; slist[8]  = 32'h0000_0014;
        slist[9] = 32'h0000_03FC; slist[10] = 32'h0000_0020; slist[11] = 32'h0000_0401;
        n_acc = 0;
        acks0 = ack_count;
        for (int k = 0; k < 18; k++) begin
            @(negedge clock);
            req_valid[0] = 1'b1;
            req_wr[0]    = 1'b0;
            req_addr[0]  = slist[k % 12];
            if (req_ready[0] === 1'b1) begin
                n_acc++;
                exp_q.push_back('{dut: 0,
                    rdata: bad_addr(slist[k % 12]) ? 32'h0 : model_a[slist[k % 12][9:2]],
                    err: bad_addr(slist[k % 12]), ack_cyc: cyc + 3});
            end
        end
        @(negedge clock);
        req_valid[0] = 1'b0;
        drain();
        repeat (3) @(negedge clock);
        check("stream_accepts", n_acc, 32'd6);
        check("stream_acks", ack_count - acks0, n_acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
